// File: rtl/cdb_arbiter_if.sv
// Writeback packet type and the FU <-> CDB arbiter bus.
// The arbiter sits on the slave side; the functional units (or a bench) drive the master side.
package cdb_pkg;
    typedef struct packed {
        logic        is_valid;
        logic [4:0]  rob_tag;
        logic [4:0]  dest_reg;
        logic [31:0] result;
    } writeback_packet_t;
endpackage

interface cdb_arbiter_if #(
    parameter int NUM_FU  = 4,
    parameter int NUM_CDB = 2
);
    import cdb_pkg::*;
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    writeback_packet_t [NUM_FU-1:0]  fu_result;
    logic              [NUM_FU-1:0]  fu_cdb_gnt;
    writeback_packet_t [NUM_CDB-1:0] cdb;
    logic              [PTR_W-1:0]   rr_ptr;

    modport master (output fu_result, input fu_cdb_gnt, input cdb, input rr_ptr);
    modport slave  (input fu_result, output fu_cdb_gnt, output cdb, output rr_ptr);
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to NUM_CDB valid FUs per cycle, combinationally,
// and registers the granted packets onto the broadcast lanes one cycle later.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU  = 4,
    parameter int NUM_CDB = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(NUM_CDB + 1);

    logic              [PTR_W-1:0]              rr_q;
    logic              [PTR_W-1:0]              rr_d;
    writeback_packet_t [NUM_CDB-1:0]            cdb_q;
    writeback_packet_t [NUM_CDB-1:0]            cdb_d;

    logic              [NUM_FU-1:0]             vld_s;
    logic              [NUM_FU-1:0]             gnt_s;
    logic                                       arb_en_s;
    logic              [NUM_CDB-1:0]            lane_vld_s;
    logic              [NUM_CDB-1:0][PTR_W-1:0] lane_sel_s;
    logic              [CNT_W-1:0]              cnt_s;
    logic              [PTR_W-1:0]              last_s;
    logic              [PTR_W:0]                sum_s;
    logic              [PTR_W-1:0]              idx_s;
    logic                                       hit_s;

    // Request vector extracted from the packets' valid bits.
    always_comb begin
        vld_s = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            vld_s[i] = bus.fu_result[i].is_valid;
        end
    end

    assign arb_en_s = !rst && !flush;

    // One-lap scan from rr_q; the j-th hit in scan order lands on lane j.
    always_comb begin
        gnt_s      = '0;
        lane_vld_s = '0;
        lane_sel_s = '0;
        cnt_s      = '0;
        last_s     = rr_q;
        sum_s      = '0;
        idx_s      = '0;
        hit_s      = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum_s  = {1'b0, rr_q} + (PTR_W+1)'(k);
            idx_s  = (sum_s >= (PTR_W+1)'(NUM_FU)) ? PTR_W'(sum_s - (PTR_W+1)'(NUM_FU))
                                                   : PTR_W'(sum_s);
            hit_s  = arb_en_s && (cnt_s < CNT_W'(NUM_CDB)) && (|(vld_s & (NUM_FU'(1) << idx_s)));
            gnt_s  = hit_s ? (gnt_s | (NUM_FU'(1) << idx_s)) : gnt_s;
            for (int j = 0; j < NUM_CDB; j++) begin
                lane_vld_s[j] = (hit_s && (cnt_s == CNT_W'(j))) ? 1'b1  : lane_vld_s[j];
                lane_sel_s[j] = (hit_s && (cnt_s == CNT_W'(j))) ? idx_s : lane_sel_s[j];
            end
            last_s = hit_s ? idx_s : last_s;
            cnt_s  = hit_s ? (cnt_s + CNT_W'(1)) : cnt_s;
        end
    end

    // Next pointer follows the last granted FU; idle cycles leave it in place.
    always_comb begin
        rr_d = rr_q;
        if (gnt_s == '0) begin
            rr_d = rr_q;
        end else if (last_s == PTR_W'(NUM_FU - 1)) begin
            rr_d = '0;
        end else begin
            rr_d = last_s + PTR_W'(1);
        end
    end

    // Lane payload mux: unassigned lanes carry an all-zero (invalid) packet.
    always_comb begin
        cdb_d = '0;
        for (int j = 0; j < NUM_CDB; j++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                cdb_d[j] = (lane_vld_s[j] && (lane_sel_s[j] == PTR_W'(i))) ? bus.fu_result[i]
                                                                           : cdb_d[j];
            end
        end
    end

    // Broadcast lanes and round-robin pointer; flush clears lanes but keeps the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q <= '0;
            rr_q  <= '0;
        end else if (flush) begin
            cdb_q <= '0;
            rr_q  <= rr_q;
        end else begin
            cdb_q <= cdb_d;
            rr_q  <= rr_d;
        end
    end

    assign bus.fu_cdb_gnt = gnt_s;
    assign bus.cdb        = cdb_q;
    assign bus.rr_ptr     = rr_q;

endmodule
